// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch stage with prefetch queue.
//   fetch_state_e : fetch controller states
//   ARM_NOP       : value presented to ID while the queue is empty (mov r0,r0)
//   PC_STEP       : byte increment between sequential instruction words
package if_fetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] ARM_NOP = 32'hE1A0_0000;
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request valid (sampled by memory on the clock edge)
//   imem_addr  : word-aligned fetch address
//   imem_ack   : one-cycle response pulse, one per accepted request
//   imem_rdata : response data, valid with imem_ack
// master = fetch stage, slave = instruction memory.
interface if_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INSN_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Prefetch FIFO holding {pc, instruction} entries.
//   clk, rst   : clock, asynchronous active-low reset
//   push/data  : write one entry at the tail
//   pop        : drop the head entry (caller guarantees non-empty)
//   flush      : clear all entries; overrides push and pop
//   count      : current occupancy (0..DEPTH)
//   head       : head entry, combinational from storage
module if_fetch_queue_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage needs no reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) storage[wr_ptr] <= push_data;
  end

  assign head = storage[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with prefetch queue in front of ID.
// Fetches words over a req/ack bus (one request outstanding, variable latency)
// and buffers up to FIFO_DEPTH {pc, instruction} pairs. A branch redirect
// flushes the queue and squashes any in-flight response.
//   clk, rst      : clock, asynchronous active-low reset
//   freeze        : ID stall, head entry held
//   Branch_taken  : redirect pulse (wins over freeze)
//   BranchAddr    : redirect target, low two bits ignored
//   imem          : instruction-memory bus (master side)
//   inst_valid    : queue non-empty
//   PC_if         : head pc (0 when empty)
//   Instruction   : head instruction (NOP_INSN when empty)
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | nothing outstanding, may issue a request
// ST_WAIT | request outstanding, response will be queued
// ST_DROP | request outstanding, response will be discarded
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                INSN_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [INSN_W-1:0] NOP_INSN   = INSN_W'(ARM_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              Branch_taken,
  input  logic [ADDR_W-1:0] BranchAddr,
  if_fetch_queue_if.master  imem,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] PC_if,
  output logic [INSN_W-1:0] Instruction
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INSN_W;

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic              issue;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] branch_pc;

  // A request is only issued while a free slot exists, so the matching
  // response can always be pushed without checking for full.
  assign issue = rst && (state == ST_IDLE) && (count < CNT_W'(FIFO_DEPTH)) && !Branch_taken;
  assign push  = (state == ST_WAIT) && imem.imem_ack && !Branch_taken;
  assign pop   = inst_valid && !freeze && !Branch_taken;

  assign branch_pc = {BranchAddr[ADDR_W-1:2], 2'b00};

  assign imem.imem_req  = issue;
  assign imem.imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
    end else if (Branch_taken) begin
      fetch_pc <= branch_pc;
      // An ack coincident with the redirect retires the outstanding request;
      // otherwise its response is still coming and must be discarded.
      unique case (state)
        ST_WAIT, ST_DROP: state <= imem.imem_ack ? ST_IDLE : ST_DROP;
        default:          state <= ST_IDLE;
      endcase
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (issue) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem.imem_ack) begin
            state    <= ST_IDLE;
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
          end
        end
        ST_DROP: begin
          if (imem.imem_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  if_fetch_queue_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fetch_pc, imem.imem_rdata}),
    .pop       (pop),
    .flush     (Branch_taken),
    .count     (count),
    .head      (head)
  );

  assign inst_valid  = (count != '0);
  assign PC_if       = inst_valid ? head[ENT_W-1:INSN_W] : '0;
  assign Instruction = inst_valid ? head[INSN_W-1:0] : NOP_INSN;

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'hE1A0_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        br = 1'b0;
  logic [31:0] baddr = '0;
  logic        inst_valid;
  logic [31:0] pc_if;
  logic [31:0] insn;

  if_fetch_queue_if #(.ADDR_W(32), .INSN_W(32)) imem ();

  if_fetch_queue #(
    .ADDR_W     (32),
    .INSN_W     (32),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (32'h0),
    .NOP_INSN   (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .Branch_taken (br),
    .BranchAddr   (baddr),
    .imem         (imem.master),
    .inst_valid   (inst_valid),
    .PC_if        (pc_if),
    .Instruction  (insn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory responder
  bit          mem_pending = 0;
  int          mem_cd = 0;
  logic [31:0] mem_addr = '0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  bit          stale_ack = 0;
  bit          release_rst = 0;
  bit          br_on_ack = 0;
  bit          br_on_wait = 0;
  logic [31:0] arm_target = '0;

  // reference model: what ID should see, in order
  ent_t        mq[$];
  bit          m_out = 0;
  bit          m_squash = 0;
  logic [31:0] m_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out    = 0;
    m_squash = 0;
    m_pc     = 32'h0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_imem_req", imem.imem_req, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_pc_if", pc_if, 32'h0);
    chk("rst_insn", insn, NOP);
  endtask

  task automatic cycle(input bit frz, input bit b, input logic [31:0] ba);
    bit          ack;
    bit          exp_req;
    logic [31:0] data;
    @(negedge clk);
    if (release_rst) begin
      rst = 1'b1;
      release_rst = 0;
    end
    ack  = 0;
    data = '0;
    if (mem_pending) begin
      mem_cd--;
      if (mem_cd == 0) begin
        ack = 1;
        data = mem_word(mem_addr);
        mem_pending = 0;
      end
    end
    if (stale_ack) begin
      ack = 1;
      data = 32'hDEAD_BEEF;
      stale_ack = 0;
    end
    if (br_on_ack && ack && m_out) begin
      b = 1; ba = arm_target; br_on_ack = 0;
    end
    if (br_on_wait && m_out && !ack) begin
      b = 1; ba = arm_target; br_on_wait = 0;
    end
    imem.imem_ack   = ack;
    imem.imem_rdata = data;
    freeze = frz;
    br     = b;
    baddr  = ba;
    #1;
    exp_req = !m_out && (mq.size() < DEPTH) && !b;
    chk("imem_req", imem.imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem.imem_addr, m_pc);
    chk("inst_valid", inst_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("pc_if", pc_if, mq[0].pc);
      chk("instruction", insn, mq[0].insn);
    end else begin
      chk("pc_if_empty", pc_if, 32'h0);
      chk("instruction_empty", insn, NOP);
    end
    if (b) begin
      mq.delete();
      if (m_out) begin
        if (ack) begin
          m_out = 0; m_squash = 0;
        end else begin
          m_squash = 1;
        end
      end
      m_pc = {ba[31:2], 2'b00};
    end else begin
      if (mq.size() != 0 && !frz) void'(mq.pop_front());
      if (ack && m_out) begin
        if (!m_squash) begin
          mq.push_back('{pc: m_pc, insn: mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
        m_out = 0;
        m_squash = 0;
      end
      if (exp_req) m_out = 1;
    end
    if (imem.imem_req) begin
      mem_pending = 1;
      mem_cd      = int'($urandom_range(lat_hi, lat_lo));
      mem_addr    = imem.imem_addr;
    end
  endtask

  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;
    model_reset();

    // reset values
    @(negedge clk);
    #1;
    check_reset_outputs();
    release_rst = 1;

    // 1: sequential fetch, latency 1, no stall
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 24; i++) cycle(0, 0, '0);

    // 2: stall until full, then drain
    for (int i = 0; i < 20; i++) cycle(1, 0, '0);
    chk("t2_full_valid", inst_valid, 1'b1);
    for (int i = 0; i < 10; i++) cycle(0, 0, '0);

    // 3: redirect while waiting, response arrives two cycles later
    lat_lo = 3; lat_hi = 3;
    arm_target = 32'h0000_0103;
    br_on_wait = 1;
    for (int i = 0; i < 20; i++) cycle(0, 0, '0);
    chk("t3_redirect_fired", br_on_wait, 1'b0);

    // 4: redirect coincident with the ack
    lat_lo = 2; lat_hi = 2;
    arm_target = 32'h0000_0202;
    br_on_ack = 1;
    for (int i = 0; i < 20; i++) cycle(0, 0, '0);
    chk("t4_redirect_fired", br_on_ack, 1'b0);

    // 5: redirect with freeze asserted and a full queue
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 30 && mq.size() < DEPTH; i++) cycle(1, 0, '0);
    chk("t5_queue_full_valid", inst_valid, 1'b1);
    cycle(1, 1, 32'h0000_0341);
    cycle(1, 0, '0);
    chk("t5_empty_after_flush", inst_valid, 1'b0);
    for (int i = 0; i < 10; i++) cycle(0, 0, '0);

    // 6: reset while a request is outstanding, stale ack afterwards
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 10 && !m_out; i++) cycle(1, 0, '0);
    chk("t6_outstanding", m_out, 1'b1);
    #2;
    rst = 1'b0;
    mem_pending = 0;
    model_reset();
    #1;
    check_reset_outputs();
    stale_ack   = 1;
    release_rst = 1;
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 16; i++) cycle(0, 0, '0);

    // randomized traffic
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 700; i++) begin
      bit          f;
      bit          b;
      logic [31:0] t;
      f = ($urandom_range(99, 0) < 30);
      b = ($urandom_range(99, 0) < 4);
      t = $urandom;
      cycle(f, b, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
